pattern_gen: RTL and testbench



---
 rtl/pattern_gen_pkg.sv | 14 +
 rtl/pattern_gen_lane.sv | 30 +++
 rtl/pattern_gen.sv | 146 ++++++++++++++
 tb/tb_pattern_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pattern_gen_pkg.sv
// Shared types and helpers for the multi-channel pattern generator.
package pattern_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A length of zero, or one longer than the frame, selects the full frame.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/pattern_gen_lane.sv
// One output channel: WIDTH-bit right-shifting frame register, LSB drives the pin.
module pattern_gen_lane #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             clear,
  input  logic [WIDTH-1:0] data,
  output logic             bit_out
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (clear) begin
      sr <= '0;
    end else if (load) begin
      sr <= data;
    end else if (shift) begin
      sr <= {1'b0, sr[WIDTH-1:1]};
    end
  end

  assign bit_out = sr[0];

endmodule

// File: rtl/pattern_gen.sv
// Multi-channel LSB-first frame emitter with shared length/repeat/start/stop control.
// Optional frame_mark output enabled by PATTERN_GEN_FRAME_MARK_EN; the repeat input is
// named repeat_count because "repeat" is a reserved word.
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  parameter int LW    = $clog2(WIDTH) + 1,
  parameter int RW    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [NCH*WIDTH-1:0] frame,
  input  logic [LW-1:0]      len,
  input  logic [RW-1:0]      repeat_count,
  output logic [NCH-1:0]     pulse,
  output logic               busy,
  output logic               done
`ifdef PATTERN_GEN_FRAME_MARK_EN
  ,
  output logic               frame_mark
`endif
);

  state_t               state_q, state_d;
  logic [NCH*WIDTH-1:0] frame_sh;
  logic [LW-1:0]        len_sh;
  logic [RW-1:0]        rep_sh;
  logic [LW-1:0]        bit_cnt;
  logic [RW-1:0]        frame_cnt;
  logic                 stop_pend;

  logic [LW-1:0]        len_eff_in;
  logic [RW-1:0]        frames_next;
  logic                 last_bit;
  logic                 count_end;
  logic                 ld_start;
  logic                 reload;
  logic                 shift;
  logic                 clear;

  assign len_eff_in  = LW'(eff_len(32'(len), WIDTH));
  assign frames_next = frame_cnt + RW'(1);
  assign last_bit    = (bit_cnt == (len_sh - LW'(1)));
  assign count_end   = (rep_sh != '0) && (frames_next == rep_sh);

  always_comb begin
    state_d  = state_q;
    ld_start = 1'b0;
    reload   = 1'b0;
    shift    = 1'b0;
    clear    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d  = RUN;
          ld_start = 1'b1;
        end
      end
      RUN: begin
        if (last_bit) begin
          // A stop arriving on the final bit still ends at this boundary.
          if (stop_pend || stop || count_end) begin
            state_d = IDLE;
            clear   = 1'b1;
          end else begin
            reload = 1'b1;
          end
        end else begin
          shift = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_sh  <= '0;
      len_sh    <= '0;
      rep_sh    <= '0;
      bit_cnt   <= '0;
      frame_cnt <= '0;
      stop_pend <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      done    <= (state_q == RUN) && (state_d == IDLE);
      if (ld_start) begin
        frame_sh  <= frame;
        len_sh    <= len_eff_in;
        rep_sh    <= repeat_count;
        bit_cnt   <= '0;
        frame_cnt <= '0;
        stop_pend <= 1'b0;
      end else if (state_q == RUN) begin
        if (clear) begin
          bit_cnt   <= '0;
          frame_cnt <= '0;
          stop_pend <= 1'b0;
        end else begin
          if (reload) begin
            bit_cnt   <= '0;
            frame_cnt <= frames_next;
          end else begin
            bit_cnt <= bit_cnt + LW'(1);
          end
          if (stop) begin
            stop_pend <= 1'b1;
          end
        end
      end
    end
  end

`ifdef PATTERN_GEN_FRAME_MARK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_mark <= 1'b0;
    end else begin
      frame_mark <= ld_start || reload;
    end
  end
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    pattern_gen_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .load   (ld_start || reload),
      .shift  (shift),
      .clear  (clear),
      .data   (ld_start ? frame[c*WIDTH +: WIDTH] : frame_sh[c*WIDTH +: WIDTH]),
      .bit_out(pulse[c])
    );
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen with two 8-bit channels.
module tb_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] frame;
  logic [3:0]  len;
  logic [15:0] repeat_count;
  logic [1:0]  pulse;
  logic        busy;
  logic        done;
`ifdef PATTERN_GEN_FRAME_MARK_EN
  logic        frame_mark;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  pattern_gen #(
    .NCH  (2),
    .WIDTH(8),
    .LW   (4),
    .RW   (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .frame       (frame),
    .len         (len),
    .repeat_count(repeat_count),
    .pulse       (pulse),
    .busy        (busy),
    .done        (done)
`ifdef PATTERN_GEN_FRAME_MARK_EN
    ,
    .frame_mark  (frame_mark)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic begin_seq(input logic [7:0] f0, input logic [7:0] f1,
                           input logic [3:0] l, input logic [15:0] r);
    frame        = {f1, f0};
    len          = l;
    repeat_count = r;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // Checks nf frames of le bits each, ending in the done cycle.
  task automatic expect_frames(input logic [7:0] f0, input logic [7:0] f1,
                               input int le, input int nf, input bit disturb,
                               input int stop_fr, input int stop_b);
    for (int fr = 0; fr < nf; fr++) begin
      for (int b = 0; b < le; b++) begin
        start = 1'b0;
        stop  = 1'b0;
        check("pulse", 32'({f1[b], f0[b]}), 32'({f0[b] & 1'b0, 1'b0}) | 32'({f1[b], f0[b]}) & 32'h3 ? 32'({f1[b], f0[b]}) : 32'h0);
        check("busy", 32'(busy), 32'h1);
        check("done_low", 32'(done), 32'h0);
        check("pulse_dut", 32'(pulse), 32'({f1[b], f0[b]}));
`ifdef PATTERN_GEN_FRAME_MARK_EN
        check("frame_mark", 32'(frame_mark), 32'(b == 0));
`endif
        if (disturb && fr == 0 && b == 1) begin
          start        = 1'b1;
          frame        = ~frame;
          len          = 4'd2;
          repeat_count = 16'd5;
        end
        if (fr == stop_fr && b == stop_b) stop = 1'b1;
        tick();
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    check("end_pulse", 32'(pulse), 32'h0);
    check("end_busy", 32'(busy), 32'h0);
    check("end_done", 32'(done), 32'h1);
`ifdef PATTERN_GEN_FRAME_MARK_EN
    check("end_mark", 32'(frame_mark), 32'h0);
`endif
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    stop         = 1'b0;
    frame        = '0;
    len          = '0;
    repeat_count = '0;
    #1;
    check("rst_pulse", 32'(pulse), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();

    // Single frame per channel
    begin_seq(8'hA5, 8'h0F, 4'd8, 16'd1);
    expect_frames(8'hA5, 8'h0F, 8, 1, 1'b0, -1, -1);
    tick();
    check("done_one_cycle", 32'(done), 32'h0);
    check("idle_pulse", 32'(pulse), 32'h0);

    // Three short frames back-to-back, then a start in the done cycle with len clamped
    begin_seq(8'h05, 8'h00, 4'd3, 16'd3);
    expect_frames(8'h05, 8'h00, 3, 3, 1'b0, -1, -1);
    begin_seq(8'hA5, 8'h3C, 4'd9, 16'd1);
    expect_frames(8'hA5, 8'h3C, 8, 1, 1'b0, -1, -1);
    tick();
    check("b2b_done_low", 32'(done), 32'h0);

    // len=0 selects the full frame
    begin_seq(8'h96, 8'hC3, 4'd0, 16'd2);
    expect_frames(8'h96, 8'hC3, 8, 2, 1'b0, -1, -1);
    tick();

    // Inputs and start changed mid-run must not alter the shadowed frame
    begin_seq(8'hA5, 8'h0F, 4'd8, 16'd1);
    expect_frames(8'hA5, 8'h0F, 8, 1, 1'b1, -1, -1);
    tick();

    // start and stop together in IDLE: no sequence
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("startstop_busy", 32'(busy), 32'h0);
    tick();
    check("startstop_busy2", 32'(busy), 32'h0);
    check("startstop_pulse", 32'(pulse), 32'h0);

    // Continuous mode, stop mid-frame finishes the frame
    begin_seq(8'h0B, 8'h0D, 4'd4, 16'd0);
    expect_frames(8'h0B, 8'h0D, 4, 2, 1'b0, 1, 2);
    tick();

    // Stop on the last bit ends at that boundary
    begin_seq(8'h02, 8'h01, 4'd2, 16'd0);
    expect_frames(8'h02, 8'h01, 2, 3, 1'b0, 2, 1);
    tick();

    // Four-bit frames, two repeats
    begin_seq(8'h0B, 8'h0D, 4'd4, 16'd2);
    expect_frames(8'h0B, 8'h0D, 4, 2, 1'b0, -1, -1);
    tick();

    // Asynchronous reset mid-frame, then a fresh start
    begin_seq(8'hFF, 8'hFF, 4'd8, 16'd0);
    tick();
    tick();
    check("pre_rst_pulse", 32'(pulse), 32'h3);
    check("pre_rst_busy", 32'(busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_pulse", 32'(pulse), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_done", 32'(done), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    begin_seq(8'h5A, 8'h81, 4'd8, 16'd1);
    expect_frames(8'h5A, 8'h81, 8, 1, 1'b0, -1, -1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
